// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes and
// multi-cycle mul/div stalls, plus a saturating count of PC stall cycles.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_Jump,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_MulDivStart,
    input  logic        EX_BranchTaken,
    output logic        PC_Stall,
    output logic        IFID_Stall,
    output logic        IDEX_Stall,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic        MD_Busy,
    output logic [31:0] StallCount
);

    typedef enum logic {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } state_t;

    localparam logic [3:0] CNT_START = 4'(MD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit;
    logic rt_hit;
    logic loaduse;

    // Register $zero never carries a real dependency, so it never forces a bubble.
    assign rs_hit  = ID_UsesRs && (ID_Rs == EX_Rd);
    assign rt_hit  = ID_UsesRt && (ID_Rt == EX_Rd);
    assign loaduse = EX_MemRead && (EX_Rd != 5'd0) && (rs_hit || rt_hit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_Stall    = 1'b0;
        IFID_Stall  = 1'b0;
        IDEX_Stall  = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;

        if (!Reset) begin
            if (state_q == MULDIV) begin
                PC_Stall    = 1'b1;
                IFID_Stall  = 1'b1;
                IDEX_Stall  = 1'b1;
                EXMEM_Flush = 1'b1;
                // A start request seen here belongs to the op already running.
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end else if (EX_MulDivStart) begin
                PC_Stall    = 1'b1;
                IFID_Stall  = 1'b1;
                IDEX_Stall  = 1'b1;
                EXMEM_Flush = 1'b1;
                state_d     = MULDIV;
                cnt_d       = CNT_START;
            end else if (EX_BranchTaken) begin
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (loaduse) begin
                // Hold IF/ID and PC, inject a bubble into ID/EX.
                PC_Stall   = 1'b1;
                IFID_Stall = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (ID_Jump) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (PC_Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MD_Busy    = !Reset && (state_q == MULDIV);
    assign StallCount = stall_cnt_q;

endmodule
